aes_dec_round_engine: RTL

Iterative AES-128 decryption engine that sequences the ten inverse rounds around the BRAM-based inverse S-box layer (aes_inv_subbytes_bram128). It takes a 128-bit ciphertext and returns a 128-bit plaintext. Round keys come from an external, combinationally indexed key store. It directly feeds the InvSubBytes stage (InvShiftRows) and consumes its output (AddRoundKey, InvMixColumns).

---
 rtl/aes_pkg.sv | 58 +++++
 rtl/aes_inv_subbytes_bram128.sv | 50 +++++
 rtl/aes_dec_round_engine.sv | 72 +++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, FSM state type and GF(2^8) round helpers
package aes_pkg;

   localparam int NR       = 10;
   localparam int RK_IDX_W = 4;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul_9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gmul_11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gmul_13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gmul_14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   // Byte k = column k/4, row k%4; row r rotates right by r.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul_14(a0) ^ gmul_11(a1) ^ gmul_13(a2) ^ gmul_9(a3);
         o[119-32*c -: 8] = gmul_9(a0)  ^ gmul_14(a1) ^ gmul_11(a2) ^ gmul_13(a3);
         o[111-32*c -: 8] = gmul_13(a0) ^ gmul_9(a1)  ^ gmul_14(a2) ^ gmul_11(a3);
         o[103-32*c -: 8] = gmul_11(a0) ^ gmul_13(a1) ^ gmul_9(a2)  ^ gmul_14(a3);
      end
      return o;
   endfunction

endpackage

// File: rtl/aes_inv_subbytes_bram128.sv
// rtl/aes_inv_subbytes_bram128.sv - 16-lane inverse S-box ROM with one-cycle registered read
module aes_inv_subbytes_bram128
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [127:0] addr,
   output logic [127:0] data
);

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Inverse affine map, then multiplicative inverse as x^254 (0 maps to 0).
   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] y, sq, r;
      y  = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      sq = y;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   logic [127:0] lookup;

   always_comb begin
      lookup = '0;
      for (int k = 0; k < 16; k++) begin
         lookup[127-8*k -: 8] = inv_sbox(addr[127-8*k -: 8]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data <= '0;
      else        data <= lookup;
   end

endmodule

// File: rtl/aes_dec_round_engine.sv
// rtl/aes_dec_round_engine.sv - iterative AES-128 decryption, two cycles per inverse round
module aes_dec_round_engine
   import aes_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [127:0]        ct_in,
   output logic [RK_IDX_W-1:0] rk_idx,
   input  logic [127:0]        rk_in,
   output logic                busy,
   output logic                done,
   output logic [127:0]        pt_out
);

   state_e              fsm;
   logic [RK_IDX_W-1:0] round;
   logic [127:0]        state_reg;
   logic [127:0]        isb;
   logic [127:0]        t;
   logic                rst_n;

   assign rst_n  = ~rst;
   assign rk_idx = (fsm == IDLE) ? RK_IDX_W'(NR) : round;
   assign t      = isb ^ rk_in;

   // Address is driven every cycle; only the value registered at the end of ADDR is consumed.
   aes_inv_subbytes_bram128 u_isb (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (inv_shift_rows(state_reg)),
      .data  (isb)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm       <= IDLE;
         round     <= '0;
         state_reg <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pt_out    <= '0;
      end else begin
         done <= 1'b0;
         case (fsm)
            IDLE: begin
               if (start) begin
                  state_reg <= ct_in ^ rk_in;
                  round     <= RK_IDX_W'(NR - 1);
                  busy      <= 1'b1;
                  fsm       <= ADDR;
               end
            end
            ADDR: fsm <= DATA;
            DATA: begin
               if (round != '0) begin
                  state_reg <= inv_mix_columns(t);
                  round     <= round - RK_IDX_W'(1);
                  fsm       <= ADDR;
               end else begin
                  pt_out <= t;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  fsm    <= IDLE;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule
